// File: rtl/serial_word_capture.sv
// Serial-to-parallel word receiver: assembles LSB-first bits into words and stores each completed
// word at an auto-incrementing address, with a registered read port for checking the contents.
module serial_word_capture #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  input  logic                          realign,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  output logic [WORD_WIDTH-1:0]         rd_data,
  output logic [WORD_WIDTH-1:0]         word_out,
  output logic                          word_valid,
  output logic [$clog2(DEPTH)-1:0]      word_addr,
  output logic [$clog2(WORD_WIDTH)-1:0] bit_count,
  output logic [$clog2(DEPTH):0]        word_count,
  output logic                          full,
  output logic                          overflow
);

  localparam int unsigned CntW  = $clog2(WORD_WIDTH);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned WcW   = AddrW + 1;

  localparam logic [CntW-1:0] LastBit   = CntW'(WORD_WIDTH - 1);
  localparam logic [WcW-1:0]  FullCount = WcW'(DEPTH);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic [WORD_WIDTH-2:0] shift_q, shift_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [WcW-1:0]        word_count_q, word_count_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic [WORD_WIDTH-1:0] word_out_q, word_out_d;
  logic [AddrW-1:0]      word_addr_q, word_addr_d;
  logic                  word_valid_q, word_valid_d;
  logic [WORD_WIDTH-1:0] rd_data_q;

  logic [CntW-1:0]       cnt_base;
  logic [WORD_WIDTH-2:0] shift_base;
  logic                  complete;
  logic                  store;
  logic [WORD_WIDTH-1:0] new_word;

  always_comb begin
    // realign zeroes the partial state before the current bit is considered
    cnt_base   = realign ? '0 : bit_cnt_q;
    shift_base = realign ? '0 : shift_q;
    complete   = bit_valid && !realign && (bit_cnt_q == LastBit);
    store      = complete && !full_q;
    new_word   = {bit_in, shift_q};

    bit_cnt_d = cnt_base;
    shift_d   = shift_base;
    if (bit_valid) begin
      if (complete) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        shift_d[cnt_base] = bit_in;
        bit_cnt_d         = cnt_base + 1'b1;
      end
    end

    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    word_out_d   = word_out_q;
    word_addr_d  = word_addr_q;
    word_valid_d = 1'b0;
    if (store) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      word_count_d = word_count_q + 1'b1;
      word_out_d   = new_word;
      word_addr_d  = wr_ptr_q;
      word_valid_d = 1'b1;
    end

    full_d     = (word_count_d == FullCount);
    overflow_d = overflow_q | (complete & full_q);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_out_q   <= '0;
      word_addr_q  <= '0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      word_out_q   <= word_out_d;
      word_addr_q  <= word_addr_d;
      word_valid_q <= word_valid_d;
    end
  end

  // Store has no reset; the non-blocking read sees pre-write contents on a same-edge collision.
  always_ff @(posedge clock) begin
    if (!clear && store) begin
      mem_q[wr_ptr_q] <= new_word;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data    = rd_data_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_addr  = word_addr_q;
  assign bit_count  = bit_cnt_q;
  assign word_count = word_count_q;
  assign full       = full_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/serial_word_capture.md
# serial_word_capture

Serial-to-parallel receive block for the bit-serial word stream produced by the mux-driven serializer, which emits each 8-bit memory word LSB first, one bit per select count. It assembles incoming bits into 8-bit words and writes each completed word into a 16-entry store at an auto-incrementing address. It reports each completion and provides a registered read port so the stored words can be checked against the source memory.

## Interface
Parameters:
- WORD_WIDTH, 8, bits per word; the bit counter is log2(WORD_WIDTH) = 3 bits wide.
- DEPTH, 16, number of word entries; the address is log2(DEPTH) = 4 bits wide.

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  reset; synchronous, active-high.
- bit_valid  in  1  qualifies bit_in on this edge.
- bit_in  in  1  serial data bit, LSB of the word first.
- realign  in  1  discards the partial word and restarts at bit 0.
- rd_addr  in  4  store read address.
- rd_data  out  8  registered store read data.
- word_out  out  8  last completed word; held until the next completion.
- word_valid  out  1  one-cycle pulse per stored word.
- word_addr  out  4  store address of word_out.
- bit_count  out  3  bits captured into the current partial word.
- word_count  out  5  words stored, 0..16.
- full  out  1  word_count == 16.
- overflow  out  1  sticky; set when a completed word is dropped.

## Operation
- Shift register: the k-th accepted bit of a word lands in bit k of that word (LSB first).
- A bit is accepted on a rising edge with bit_valid=1. Each accepted bit increments bit_count, which wraps 7 -> 0.
- Word completion: an accepted bit with bit_count=7. The completed word is {bit_in, shift[6:0]}.
  - If not full: write the word to mem[wr_ptr]; word_out <= word; word_addr <= wr_ptr; word_valid <= 1; wr_ptr <= wr_ptr+1 (4-bit, 15 -> 0); word_count <= word_count+1.
  - If full: the word is dropped. The store, word_out, word_addr and word_count are unchanged, word_valid stays 0, and overflow <= 1.
- bit_count returns to 0 after every completion, whether the word is stored or dropped.
- realign=1 sets bit_count to 0 and discards shifted bits.
  - If bit_valid=1 in the same cycle, that bit is accepted as bit 0 of the new word, and bit_count becomes 1.
  - realign never completes a word.
- word_count saturates at 16. Only clear empties the store; there is no drain.
- Store read: rd_data <= mem[rd_addr] on every edge.
  - A read and write to the same address on the same edge returns the old contents (read-before-write).
- Reset (clear=1 on an edge) overrides all other inputs:
  - rd_data, word_out, word_addr, bit_count, word_count, wr_ptr and the shift register go to 0.
  - word_valid, full and overflow go to 0.
  - Store contents are not cleared. Reads of unwritten addresses are unspecified.
- Reset mid-word discards the partial word. The first accepted bit after reset is bit 0.

## Timing
- Latency: the word is visible on word_out, word_addr and word_valid in the cycle after the edge that samples the 8th bit.
  - word_count and full update on that same edge.
  - The store entry is readable by an rd_addr presented in that cycle, with rd_data on the following edge.
- Read latency: rd_data is valid one cycle after rd_addr.
- word_valid is high for exactly one cycle per stored word.
- Back-to-back words at one bit per cycle give a word_valid pulse every 8 cycles.
- bit_valid may deassert for any number of cycles between bits. The shift state holds, with no timeout.
- full is registered and asserts in the same cycle as the 16th word_valid.
- overflow asserts in the cycle after the dropped 8th bit and holds until clear.

## Test plan
- Word 0xAA, sent LSB first as bits 0,1,0,1,0,1,0,1 on consecutive cycles after clear:
  - word_valid pulses once, one cycle after the 8th bit.
  - word_out=0xAA, word_addr=0, word_count=1.
  - rd_addr=0 gives rd_data=0xAA one cycle later.
- Word 0xCC following 0xAA, with bit_valid gapped (1 bit every 3 cycles):
  - word_out=0xCC, word_addr=1, word_count=2.
  - No word_valid during the gaps.
- Realign: send 3 bits, then realign with no bit_valid, then send 0x5A:
  - One word_valid only, with word_out=0x5A.
  - Repeat with realign and bit_valid together: that bit becomes bit 0 and bit_count=1.
- Fill: send words 0x00..0x0F, then 0xFF:
  - full=1 with the 16th pulse, word_count=16.
  - 0xFF produces no word_valid; overflow=1; word_out remains 0x0F.
  - Reads of addresses 0..15 return 0x00..0x0F.
- Clear mid-word: after 5 bits, assert clear for 1 cycle, then send 0x3C:
  - All outputs are 0 after clear.
  - The next word_valid has word_out=0x3C, word_addr=0, and overflow stays 0.
- Same-edge read and write: hold rd_addr=2 while word 2 (0x77) completes:
  - The first rd_data shows the old contents.
  - The next cycle shows 0x77.
